// File: rtl/piezo_pkg.sv
// Shared types and per-source tone/cadence tables for the piezo sound arbiter.
// Half-periods are derived from the clock frequency so one RTL serves any CLK_HZ.
package piezo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int NSRC = 4;

  localparam logic [1:0] SRC_HORN = 2'd0;
  localparam logic [1:0] SRC_ESS  = 2'd1;
  localparam logic [1:0] SRC_REV  = 2'd2;
  localparam logic [1:0] SRC_TURN = 2'd3;

  function automatic longint tone_hz(input logic [1:0] src);
    case (src)
      SRC_HORN: return 64'd440;
      SRC_ESS:  return 64'd1000;
      SRC_REV:  return 64'd800;
      default:  return 64'd2000;
    endcase
  endfunction

  // Clamped to 1..65535 so the 16-bit half-period counter always has a valid terminal value.
  function automatic logic [15:0] half_of(input longint clk_hz, input logic [1:0] src);
    longint h;
    h = clk_hz / (64'd2 * tone_hz(src));
    if (h > 64'd65535) h = 64'd65535;
    else if (h < 64'd1) h = 64'd1;
    return h[15:0];
  endfunction

  function automatic logic [9:0] on_ms_of(input logic [1:0] src);
    case (src)
      SRC_HORN: return 10'd1;
      SRC_ESS:  return 10'd100;
      SRC_REV:  return 10'd500;
      default:  return 10'd30;
    endcase
  endfunction

  // An OFF time of zero means the source plays continuously.
  function automatic logic [9:0] off_ms_of(input logic [1:0] src);
    case (src)
      SRC_HORN: return 10'd0;
      SRC_ESS:  return 10'd100;
      SRC_REV:  return 10'd500;
      default:  return 10'd470;
    endcase
  endfunction

endpackage

// File: rtl/piezo_tone_gen.sv
// Square-wave generator with ms-based on/off cadence; wave is registered.
// restart forces wave=0 and starts a fresh ON phase on the next cycle.
module piezo_tone_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        restart,
  input  logic [15:0] half_period,
  input  logic [9:0]  on_ms,
  input  logic [9:0]  off_ms,
  input  logic        ms_tick,
  output logic        wave
);

  logic [15:0] tone_cnt;
  logic [9:0]  ms_cnt;
  logic        on_phase;
  logic        cadenced;
  logic        phase_end;

  assign cadenced  = (off_ms != 10'd0);
  assign phase_end = cadenced && ms_tick &&
                     (ms_cnt == ((on_phase ? on_ms : off_ms) - 10'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tone_cnt <= 16'd0;
      ms_cnt   <= 10'd0;
      on_phase <= 1'b1;
      wave     <= 1'b0;
    end else if (restart) begin
      tone_cnt <= 16'd0;
      ms_cnt   <= 10'd0;
      on_phase <= 1'b1;
      wave     <= 1'b0;
    end else begin
      if (cadenced && ms_tick)
        ms_cnt <= phase_end ? 10'd0 : ms_cnt + 10'd1;
      if (phase_end) begin
        // Both phase boundaries leave the tone silent and phase-aligned to zero.
        on_phase <= !on_phase;
        tone_cnt <= 16'd0;
        wave     <= 1'b0;
      end else if (on_phase) begin
        if (tone_cnt == half_period - 16'd1) begin
          wave     <= !wave;
          tone_cnt <= 16'd0;
        end else begin
          tone_cnt <= tone_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: rtl/piezo_sound_arbiter.sv
// Fixed-priority preemptive arbiter sharing one piezo between four sound sources.
// All outputs registered: grant follows a request by one cycle; releases pass through a silent gap.
module piezo_sound_arbiter
  import piezo_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int GAP_MS = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] en_mask,
  output logic [3:0] grant,
  output logic       busy,
  output logic       piezo_out
);

  localparam int              TICK_DIV  = CLK_HZ / 1000;
  localparam int              TW        = $clog2(TICK_DIV);
  localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [15:0]     GAP_LAST  = 16'(GAP_MS - 1);
  localparam logic [15:0]     HALF_HORN = half_of(longint'(CLK_HZ), SRC_HORN);
  localparam logic [15:0]     HALF_ESS  = half_of(longint'(CLK_HZ), SRC_ESS);
  localparam logic [15:0]     HALF_REV  = half_of(longint'(CLK_HZ), SRC_REV);
  localparam logic [15:0]     HALF_TURN = half_of(longint'(CLK_HZ), SRC_TURN);

  state_t        state, state_n;
  logic [1:0]    owner, owner_n;
  logic [1:0]    hi_idx;
  logic [3:0]    ereq;
  logic          any_req;
  logic [TW-1:0] tick_cnt;
  logic          ms_tick;
  logic [15:0]   gap_cnt;
  logic          restart;
  logic [15:0]   half_sel;
  logic          wave;

  assign ereq    = req & en_mask;
  assign any_req = |ereq;
  assign ms_tick = (tick_cnt == TICK_LAST);

  always_comb begin
    hi_idx = 2'd0;
    for (int i = NSRC - 1; i >= 0; i--)
      if (ereq[i]) hi_idx = 2'(i);
  end

  always_comb begin
    state_n = state;
    owner_n = owner;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          state_n = ST_PLAY;
          owner_n = hi_idx;
        end
      end
      ST_PLAY: begin
        // Preemption wins over release, so a simultaneous release+higher request skips the gap.
        if (any_req && (hi_idx < owner))
          owner_n = hi_idx;
        else if (!ereq[owner])
          state_n = any_req ? ST_GAP : ST_IDLE;
      end
      ST_GAP: begin
        if (ms_tick && (gap_cnt == GAP_LAST)) begin
          state_n = any_req ? ST_PLAY : ST_IDLE;
          owner_n = hi_idx;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Tone is held cleared whenever no grant continues unchanged into the next cycle.
  assign restart = (state != ST_PLAY) || (state_n != ST_PLAY) || (owner_n != owner);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      owner    <= 2'd0;
      grant    <= 4'd0;
      busy     <= 1'b0;
      tick_cnt <= '0;
      gap_cnt  <= 16'd0;
    end else begin
      state    <= state_n;
      owner    <= owner_n;
      grant    <= (state_n == ST_PLAY) ? (4'b0001 << owner_n) : 4'b0000;
      busy     <= (state_n != ST_IDLE);
      tick_cnt <= ms_tick ? '0 : tick_cnt + TW'(1);
      if (state != ST_GAP)
        gap_cnt <= 16'd0;
      else if (ms_tick)
        gap_cnt <= gap_cnt + 16'd1;
    end
  end

  always_comb begin
    case (owner)
      SRC_HORN: half_sel = HALF_HORN;
      SRC_ESS:  half_sel = HALF_ESS;
      SRC_REV:  half_sel = HALF_REV;
      default:  half_sel = HALF_TURN;
    endcase
  end

  piezo_tone_gen u_tone (
    .clk         (clk),
    .rst_n       (rst_n),
    .restart     (restart),
    .half_period (half_sel),
    .on_ms       (on_ms_of(owner)),
    .off_ms      (off_ms_of(owner)),
    .ms_tick     (ms_tick),
    .wave        (wave)
  );

  assign piezo_out = wave;

endmodule

// File: tb/tb_piezo_sound_arbiter.sv
// Directed bench for piezo_sound_arbiter at CLK_HZ=20_000 (1 ms = 20 cycles) with a per-cycle reference model.
module tb_piezo_sound_arbiter;

  localparam int CLK_HZ = 20_000;
  localparam int GAP_MS = 20;
  localparam int DIV    = CLK_HZ / 1000;
  // floor(20000 / (2*f)) for 440 Hz, 1 kHz, 800 Hz, 2 kHz
  localparam int HALF  [4] = '{22, 10, 12, 5};
  localparam int ONMS  [4] = '{1, 100, 500, 30};
  localparam int OFFMS [4] = '{0, 100, 500, 470};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] en_mask = 4'b1111;
  logic [3:0] grant;
  logic       busy;
  logic       piezo_out;

  int n_chk = 0;
  int n_err = 0;

  piezo_sound_arbiter #(.CLK_HZ(CLK_HZ), .GAP_MS(GAP_MS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .en_mask   (en_mask),
    .grant     (grant),
    .busy      (busy),
    .piezo_out (piezo_out)
  );

  always #5 clk = ~clk;

  // Reference model: state 0=idle 1=playing 2=gap; wave derived from elapsed time in the current ON phase.
  int         e;
  int         m_state;
  int         m_owner;
  int         m_gap;
  int         m_ticks;
  bit         m_on;
  int         m_pstart;
  int         hi;
  bit         tick;
  bit         start;
  logic [3:0] ereq;
  logic [3:0] m_grant;
  bit         m_busy;
  bit         m_wave;

  function automatic int highest(input logic [3:0] v);
    for (int i = 0; i < 4; i++)
      if (v[i]) return i;
    return 4;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e = 0; m_state = 0; m_owner = 0; m_gap = 0; m_ticks = 0; m_on = 1; m_pstart = 0;
    end else begin
      e++;
      tick  = (e % DIV == 0);
      ereq  = req & en_mask;
      hi    = highest(ereq);
      start = 0;
      case (m_state)
        0: if (hi < 4) begin m_state = 1; m_owner = hi; start = 1; end
        1: begin
          if (hi < m_owner) begin
            m_owner = hi; start = 1;
          end else if (!ereq[m_owner]) begin
            m_state = (hi < 4) ? 2 : 0;
            m_gap = 0;
          end else if (OFFMS[m_owner] != 0 && tick) begin
            m_ticks++;
            if (m_ticks == (m_on ? ONMS[m_owner] : OFFMS[m_owner])) begin
              m_on = !m_on; m_ticks = 0; m_pstart = e;
            end
          end
        end
        default: if (tick) begin
          m_gap++;
          if (m_gap == GAP_MS) begin
            if (hi < 4) begin m_state = 1; m_owner = hi; start = 1; end
            else m_state = 0;
          end
        end
      endcase
      if (start) begin m_on = 1; m_ticks = 0; m_pstart = e; end
    end
    m_grant = (m_state == 1) ? 4'(1 << m_owner) : 4'b0000;
    m_busy  = (m_state != 0);
    m_wave  = (m_state == 1 && m_on) ? (((e - m_pstart) / HALF[m_owner]) % 2 == 1) : 1'b0;
  end

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_grant", grant, m_grant);
    chk("model_busy", {3'b000, busy}, {3'b000, m_busy});
    chk("model_piezo", {3'b000, piezo_out}, {3'b000, m_wave});
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    cyc(3);
    chk("reset_grant", grant, 4'b0000);
    chk("reset_busy", {3'b000, busy}, 4'b0000);
    chk("reset_piezo", {3'b000, piezo_out}, 4'b0000);
    rst_n = 1'b1;
    cyc(4);

    // Reverse alone: 12-cycle half period, long enough run to cross into the OFF phase
    req = 4'b0100;
    cyc(1);
    chk("rev_grant", grant, 4'b0100);
    chk("rev_first_cycle_silent", {3'b000, piezo_out}, 4'b0000);
    cyc(11);
    chk("rev_k11_low", {3'b000, piezo_out}, 4'b0000);
    cyc(1);
    chk("rev_k12_high", {3'b000, piezo_out}, 4'b0001);
    cyc(10600);

    // Horn preempts reverse with no gap
    req = 4'b0101;
    cyc(1);
    chk("horn_preempt_grant", grant, 4'b0001);
    chk("horn_preempt_busy", {3'b000, busy}, 4'b0001);
    chk("horn_first_cycle_silent", {3'b000, piezo_out}, 4'b0000);
    cyc(21);
    chk("horn_k21_low", {3'b000, piezo_out}, 4'b0000);
    cyc(1);
    chk("horn_k22_high", {3'b000, piezo_out}, 4'b0001);
    cyc(200);

    // Horn released with turn pending: 20 ms gap then turn burst
    req = 4'b1000;
    cyc(1);
    chk("gap_grant0", grant, 4'b0000);
    chk("gap_busy", {3'b000, busy}, 4'b0001);
    cyc(379);
    chk("gap_k380_still_gap", grant, 4'b0000);
    cyc(20);
    chk("gap_k400_turn", grant, 4'b1000);
    cyc(1000);

    // Masked request stays idle until enabled
    req = 4'b0000;
    cyc(2);
    en_mask = 4'b1101;
    req = 4'b0010;
    cyc(5);
    chk("masked_grant", grant, 4'b0000);
    chk("masked_busy", {3'b000, busy}, 4'b0000);
    chk("masked_piezo", {3'b000, piezo_out}, 4'b0000);
    en_mask = 4'b1111;
    cyc(1);
    chk("unmask_grant", grant, 4'b0010);
    cyc(50);

    // Asynchronous reset mid-play
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_grant", grant, 4'b0000);
    chk("async_rst_busy", {3'b000, busy}, 4'b0000);
    chk("async_rst_piezo", {3'b000, piezo_out}, 4'b0000);
    cyc(3);
    rst_n = 1'b1;
    cyc(1);
    chk("post_rst_grant", grant, 4'b0010);
    cyc(30);

    // Owner release and horn request in the same cycle: direct switch
    req = 4'b0001;
    cyc(1);
    chk("direct_switch_grant", grant, 4'b0001);
    chk("direct_switch_busy", {3'b000, busy}, 4'b0001);
    cyc(40);

    // A new request during the gap does not shorten it
    req = 4'b1001;
    cyc(5);
    req = 4'b1000;
    cyc(1);
    chk("gap2_grant0", grant, 4'b0000);
    cyc(199);
    req = 4'b1001;
    cyc(181);
    chk("gap2_k380_not_shortened", grant, 4'b0000);
    cyc(20);
    chk("gap2_k400_horn", grant, 4'b0001);
    cyc(30);

    // en_mask clearing the owner acts as a release
    req = 4'b0001;
    en_mask = 4'b1110;
    cyc(1);
    chk("mask_release_grant", grant, 4'b0000);
    chk("mask_release_busy", {3'b000, busy}, 4'b0000);
    en_mask = 4'b1111;
    cyc(1);
    chk("remask_grant", grant, 4'b0001);

    // Gap expiring with nothing pending returns to idle
    req = 4'b0011;
    cyc(5);
    req = 4'b0010;
    cyc(1);
    chk("gap3_busy", {3'b000, busy}, 4'b0001);
    cyc(100);
    req = 4'b0000;
    cyc(300);
    chk("gap3_end_idle_busy", {3'b000, busy}, 4'b0000);
    chk("gap3_end_idle_grant", grant, 4'b0000);
    cyc(5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
